store_exec_unit: RTL

- Consumer end of the store reservation station issue interface. Takes one issued store per handshake and drives it onto a single-port data-memory write interface.
- Waits for memory acknowledge, with a timeout.
- Reports completion (tag plus error flag) so the station and ROB-side logic can retire the entry.
- Sits between the store station and the data memory.

---
 rtl/store_exec_unit_pkg.sv | 22 ++
 rtl/store_exec_unit_if.sv | 42 ++++
 rtl/store_exec_unit_lane_align.sv | 51 +++++
 rtl/store_exec_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/store_exec_unit_pkg.sv
// store_exec_unit_pkg
// Shared definitions for the store execution unit slice: the store opcode
// encoding used by the reservation station, the operand and tag widths, and
// the state encoding of the unit's controller.
// Ports: none (package).
package store_exec_unit_pkg;

  localparam int OP_W   = 5;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] OP_SW = 5'd1;
  localparam logic [OP_W-1:0] OP_SH = 5'd2;
  localparam logic [OP_W-1:0] OP_SB = 5'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/store_exec_unit_if.sv
// store_exec_unit_if
// Bundles the store-station issue handshake, the data-memory write port and
// the completion report of the store execution unit.
//   master : station / memory / retire side (drives issue fields, memReady)
//   slave  : the store execution unit itself
// Signals:
//   OutEn, opIn, dataIn1, dataIn2, labelIn : issued store from the station
//   EXEable                                : unit can accept a store
//   memReq, memAddr, memWdata, memBe       : memory write request and payload
//   memReady                               : memory accepts the write
//   doneEn, doneLabel, doneErr             : completion pulse, tag, error flag
interface store_exec_unit_if;
  import store_exec_unit_pkg::*;

  logic              OutEn;
  logic [OP_W-1:0]   opIn;
  logic [DATA_W-1:0] dataIn1;
  logic [DATA_W-1:0] dataIn2;
  logic [TAG_W-1:0]  labelIn;
  logic              EXEable;
  logic              memReq;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [3:0]        memBe;
  logic              memReady;
  logic              doneEn;
  logic [TAG_W-1:0]  doneLabel;
  logic              doneErr;

  modport master (
    output OutEn, opIn, dataIn1, dataIn2, labelIn, memReady,
    input  EXEable, memReq, memAddr, memWdata, memBe,
           doneEn, doneLabel, doneErr
  );

  modport slave (
    input  OutEn, opIn, dataIn1, dataIn2, labelIn, memReady,
    output EXEable, memReq, memAddr, memWdata, memBe,
           doneEn, doneLabel, doneErr
  );

endinterface

// File: rtl/store_exec_unit_lane_align.sv
// store_lane_align
// Purely combinational lane steering for a single store. Maps the opcode,
// the low two address bits and the raw store data onto the byte enables and
// the replicated write data of a 32-bit word-addressed memory port.
// Ports:
//   op         in  store opcode (OP_SW / OP_SH / OP_SB)
//   addrLo     in  byte offset within the word
//   data       in  raw store data
//   be         out byte enables
//   wdata      out lane-replicated write data
//   misaligned out store cannot be issued (bad alignment or unknown opcode)
module store_lane_align
  import store_exec_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        addrLo,
  input  logic [DATA_W-1:0] data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic              misaligned
);

  // Narrow stores replicate their data across all lanes so the memory only
  // needs the byte enables to pick the right bytes. An unknown opcode is
  // folded into misaligned because both lead to the same error completion.
  always_comb begin
    be         = 4'b0000;
    wdata      = data;
    misaligned = 1'b0;
    case (op)
      OP_SW: begin
        be         = 4'b1111;
        wdata      = data;
        misaligned = (addrLo != 2'b00);
      end
      OP_SH: begin
        be         = addrLo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addrLo[0];
      end
      OP_SB: begin
        be    = 4'b0001 << addrLo;
        wdata = {4{data[7:0]}};
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_exec_unit.sv
// store_exec_unit
// Consumer end of the store reservation station. Accepts one issued store
// per handshake, drives it onto a single-port data-memory write interface,
// waits for memReady with a bounded timeout and reports completion (tag plus
// error flag) for retirement. All interface outputs are registered.
// Parameters:
//   TIMEOUT : cycles spent in REQ without memReady before the store aborts
//   CNT_W   : width of the timeout counter (must hold TIMEOUT)
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : store_exec_unit_if.slave (issue, memory write, completion)
//   storeCnt   : completed-without-error count (STORE_EXEC_STATS_EN only)
//   errCnt     : completed-with-error count    (STORE_EXEC_STATS_EN only)
// Optional feature macro: STORE_EXEC_STATS_EN
module store_exec_unit
  import store_exec_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  store_exec_unit_if.slave      bus
`ifdef STORE_EXEC_STATS_EN
  ,
  output logic [15:0]           storeCnt,
  output logic [15:0]           errCnt
`endif
);

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              exeQ, exeNext;
  logic              reqQ, reqNext;
  logic [DATA_W-1:0] addrQ, addrNext;
  logic [DATA_W-1:0] wdataQ, wdataNext;
  logic [3:0]        beQ, beNext;
  logic              doneEnQ, doneEnNext;
  logic [TAG_W-1:0]  labelQ, labelNext;
  logic              errQ, errNext;

  logic [3:0]        laneBe;
  logic [DATA_W-1:0] laneWdata;
  logic              laneBad;

  store_lane_align uAlign (
    .op         (bus.opIn),
    .addrLo     (bus.dataIn1[1:0]),
    .data       (bus.dataIn2),
    .be         (laneBe),
    .wdata      (laneWdata),
    .misaligned (laneBad)
  );

  // Next-state and next-output logic. Every output is computed here one
  // cycle ahead so the register stage below keeps them glitch-free. Bad
  // stores skip REQ entirely and complete with an error on the next cycle.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    exeNext    = exeQ;
    reqNext    = reqQ;
    addrNext   = addrQ;
    wdataNext  = wdataQ;
    beNext     = beQ;
    doneEnNext = 1'b0;
    labelNext  = labelQ;
    errNext    = errQ;
    case (state)
      IDLE: begin
        exeNext = 1'b1;
        if (bus.OutEn && exeQ) begin
          labelNext = bus.labelIn;
          exeNext   = 1'b0;
          cntNext   = '0;
          if (laneBad) begin
            stateNext  = DONE;
            doneEnNext = 1'b1;
            errNext    = 1'b1;
          end else begin
            stateNext = REQ;
            reqNext   = 1'b1;
            addrNext  = {bus.dataIn1[31:2], 2'b00};
            wdataNext = laneWdata;
            beNext    = laneBe;
          end
        end
      end
      REQ: begin
        // memReady is checked first so it wins on the timeout edge.
        if (bus.memReady) begin
          stateNext  = DONE;
          reqNext    = 1'b0;
          doneEnNext = 1'b1;
          errNext    = 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          stateNext  = DONE;
          reqNext    = 1'b0;
          doneEnNext = 1'b1;
          errNext    = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
        exeNext   = 1'b1;
        cntNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        exeNext   = 1'b1;
        reqNext   = 1'b0;
        cntNext   = '0;
      end
    endcase
  end

  // State and output registers. Reset drops memReq at once, which is what
  // abandons an in-flight store without ever raising doneEn for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      exeQ    <= 1'b1;
      reqQ    <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      beQ     <= 4'b0000;
      doneEnQ <= 1'b0;
      labelQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      exeQ    <= exeNext;
      reqQ    <= reqNext;
      addrQ   <= addrNext;
      wdataQ  <= wdataNext;
      beQ     <= beNext;
      doneEnQ <= doneEnNext;
      labelQ  <= labelNext;
      errQ    <= errNext;
    end
  end

  assign bus.EXEable   = exeQ;
  assign bus.memReq    = reqQ;
  assign bus.memAddr   = addrQ;
  assign bus.memWdata  = wdataQ;
  assign bus.memBe     = beQ;
  assign bus.doneEn    = doneEnQ;
  assign bus.doneLabel = labelQ;
  assign bus.doneErr   = errQ;

`ifdef STORE_EXEC_STATS_EN
  // Completion statistics, split by error flag. Both simply wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      storeCnt <= 16'h0000;
      errCnt   <= 16'h0000;
    end else if (doneEnQ) begin
      if (errQ) begin
        errCnt <= errCnt + 16'h0001;
      end else begin
        storeCnt <= storeCnt + 16'h0001;
      end
    end
  end
`endif

endmodule
